// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, valid/ready in and out.
// Define FAST_MUL_EN to route MUL* ops through a single-cycle multiplier instead.
module mdu_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic         busy
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [2*N-1:0]   prod_q;
    logic [2*N-1:0]   prod_d;
    logic [N-1:0]     mc_q;
    logic             neg_q;
    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     res_q;

    logic             sgn_a, sgn_b, sa, sb, neg_in;
    logic [N-1:0]     ma, mb;
    logic             b_zero, ovf, special;
    logic [N-1:0]     spec_res;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res       = res_q;

    // Undo the magnitude conversion and pick the half of the result the op returns.
    function automatic logic [N-1:0] fixup(
        input logic [2:0]     o,
        input logic [2*N-1:0] p,
        input logic           n
    );
        logic [2*N-1:0] pf;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        pf = n ? -p : p;
        q  = n ? -p[N-1:0] : p[N-1:0];
        r  = n ? -p[2*N-1:N] : p[2*N-1:N];
        case (o)
            3'b000:                fixup = pf[N-1:0];
            3'b001, 3'b010, 3'b011: fixup = pf[2*N-1:N];
            3'b100, 3'b101:        fixup = q;
            default:               fixup = r;
        endcase
    endfunction

    // Operand sign handling and RISC-V divide corner cases, evaluated at accept.
    always_comb begin
        sgn_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sgn_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa       = sgn_a && a[N-1];
        sb       = sgn_b && b[N-1];
        ma       = sa ? -a : a;
        mb       = sb ? -b : b;
        neg_in   = (op[2] && op[1]) ? sa : (sa ^ sb);
        b_zero   = (b == '0);
        ovf      = ((op == 3'b100) || (op == 3'b110))
                   && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
        special  = op[2] && (b_zero || ovf);
        if (b_zero)
            spec_res = op[1] ? a : '1;
        else
            spec_res = op[1] ? '0 : a;
    end

`ifdef FAST_MUL_EN
    logic [2*N-1:0] fast_prod;
    assign fast_prod = {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
`endif

    // One shift-add or restoring-subtract step on the shared product/remainder register.
    always_comb begin
        logic [N:0] sum;
        logic [N:0] trial;
        logic [N:0] diff;
        sum    = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mc_q} : '0);
        trial  = {prod_q[2*N-1:N], prod_q[N-1]};
        diff   = trial - {1'b0, mc_q};
        prod_d = '0;
        if (!op_q[2])
            prod_d = {sum, prod_q[N-1:1]};
        else if (!diff[N])
            prod_d = {diff[N-1:0], prod_q[N-2:0], 1'b1};
        else
            prod_d = {trial[N-1:0], prod_q[N-2:0], 1'b0};
    end

    // Control FSM with the datapath registers it loads and advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            prod_q  <= '0;
            mc_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        neg_q <= neg_in;
                        cnt_q <= CW'(N-1);
                        if (special) begin
                            res_q   <= spec_res;
                            state_q <= DONE;
`ifdef FAST_MUL_EN
                        end else if (!op[2]) begin
                            res_q   <= fixup(op, fast_prod, neg_in);
                            state_q <= DONE;
`endif
                        end else begin
                            prod_q  <= op[2] ? {{N{1'b0}}, ma} : {{N{1'b0}}, mb};
                            mc_q    <= op[2] ? mb : ma;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        res_q   <= fixup(op_q, prod_d, neg_q);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter at N=32.
// Latency expectations for MUL* follow the FAST_MUL_EN build selection.
module tb_mdu_iter;

    localparam int LAT_IT = 33;
`ifdef FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_iter #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_valid(output int lat, output bit saw_rdy);
        lat = 1;
        saw_rdy = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) saw_rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (in_ready) saw_rdy = 1'b1;
    endtask

    task automatic retire;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat, output bit saw_rdy);
        start_op(o, x, y);
        wait_valid(lat, saw_rdy);
        r = res;
        retire();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_hold rdy/ov/busy/res got %b%b%b %h exp 100 00000000",
                     in_ready, out_valid, busy, res);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release rdy/busy got %b%b exp 10", in_ready, busy);
        end
    endtask

    task automatic test_mul;
        logic [31:0] r;
        int lat;
        bit saw;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, saw);
        n_cmp++;
        if (r !== 32'hFFFFFFEB) begin
            n_bad++;
            $display("FAIL mul_res got %h exp ffffffeb", r);
        end
        n_cmp++;
        if (lat !== LAT_MUL) begin
            n_bad++;
            $display("FAIL mul_latency got %0d exp %0d", lat, LAT_MUL);
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_in_ready got %b exp 0", saw);
        end
    endtask

    task automatic test_mulh;
        logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] xs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ys  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] r;
        int lat;
        bit saw;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], xs[i], ys[i], r, lat, saw);
            n_cmp++;
            if (r !== ex[i]) begin
                n_bad++;
                $display("FAIL mulh[%0d] res got %h exp %h", i, r, ex[i]);
            end
            n_cmp++;
            if (lat !== LAT_MUL) begin
                n_bad++;
                $display("FAIL mulh[%0d] latency got %0d exp %0d", i, lat, LAT_MUL);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] xs  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] ys  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] ex  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        logic [31:0] r;
        int lat;
        bit saw;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], xs[i], ys[i], r, lat, saw);
            n_cmp++;
            if (r !== ex[i]) begin
                n_bad++;
                $display("FAIL div[%0d] res got %h exp %h", i, r, ex[i]);
            end
            n_cmp++;
            if (lat !== LAT_IT) begin
                n_bad++;
                $display("FAIL div[%0d] latency got %0d exp %0d", i, lat, LAT_IT);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]  ops [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] xs  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] ys  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] r;
        int lat;
        bit saw;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], r, lat, saw);
            n_cmp++;
            if (r !== ex[i]) begin
                n_bad++;
                $display("FAIL special[%0d] res got %h exp %h", i, r, ex[i]);
            end
            n_cmp++;
            if (lat !== 1) begin
                n_bad++;
                $display("FAIL special[%0d] latency got %0d exp 1", i, lat);
            end
        end
    endtask

    task automatic test_hold_flush;
        logic [31:0] r;
        int lat;
        bit saw;
        int spur;
        start_op(3'b101, 32'd100, 32'd7);
        wait_valid(lat, saw);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || res !== 32'd14 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d] ov/res/rdy got %b %h %b exp 1 0000000e 0",
                         i, out_valid, res, in_ready);
            end
        end
        retire();
        start_op(3'b000, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_in_ready got %b exp 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle busy/ov got %b%b exp 00", busy, out_valid);
        end
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        n_cmp++;
        if (spur !== 0) begin
            n_bad++;
            $display("FAIL flush_no_result out_valid cycles got %0d exp 0", spur);
        end
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, saw);
        n_cmp++;
        if (r !== 32'hFFFFFFFE || lat !== LAT_MUL) begin
            n_bad++;
            $display("FAIL post_flush res/lat got %h %0d exp fffffffe %0d", r, lat, LAT_MUL);
        end
    endtask

    task automatic test_rst_mid;
        logic [31:0] r;
        int lat;
        bit saw;
        int spur;
        start_op(3'b101, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid rdy/ov/busy/res got %b%b%b %h exp 100 00000000",
                     in_ready, out_valid, busy, res);
        end
        @(negedge clk);
        rst = 1'b0;
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        n_cmp++;
        if (spur !== 0) begin
            n_bad++;
            $display("FAIL rst_no_result out_valid cycles got %0d exp 0", spur);
        end
        run_op(3'b101, 32'd9, 32'd3, r, lat, saw);
        n_cmp++;
        if (r !== 32'd3 || lat !== LAT_IT) begin
            n_bad++;
            $display("FAIL post_rst res/lat got %h %0d exp 00000003 %0d", r, lat, LAT_IT);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        op = 3'b000;
        a = '0;
        b = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_hold_flush();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
